// File: rtl/multu_if.sv
// multu_if: operand/request and HI/LO/status bundle between ID/EX and multu_unit
interface multu_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;
  modport master (output start, a, b, input hi, lo, busy, done, stall);
  modport slave  (input start, a, b, output hi, lo, busy, done, stall);
endinterface

// File: rtl/multu_unit.sv
// multu_unit: WIDTH-iteration shift-add unsigned multiplier writing HI/LO, stalling ID/EX while in flight
module multu_unit #(parameter int WIDTH = 32) (
  input logic   clk,
  input logic   rst,
  multu_if.slave m
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  localparam int CW = $clog2(WIDTH);
  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod, prod_nx;
  logic [WIDTH-1:0]   mcand, hi, lo;
  logic [WIDTH:0]     sum;
  always_comb begin
    sum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_nx = {sum, prod[WIDTH-1:1]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      prod  <= '0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (state == IDLE && m.start) begin
      mcand <= m.a;
      prod  <= {{WIDTH{1'b0}}, m.b};
      cnt   <= '0;
      state <= RUN;
    end else if (state == RUN) begin
      prod <= prod_nx;
      cnt  <= cnt + 1'b1;
      if (cnt == CW'(WIDTH - 1)) begin
        hi    <= prod_nx[2*WIDTH-1:WIDTH];
        lo    <= prod_nx[WIDTH-1:0];
        state <= DONE;
      end
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
  // start->stall is the only combinational path, so ID/EX freezes in the issuing cycle
  assign m.stall = ~rst & ((state == IDLE & m.start) | state == RUN);
  assign m.busy  = state == RUN;
  assign m.done  = state == DONE;
  assign m.hi    = hi;
  assign m.lo    = lo;
endmodule

// File: tb/tb_multu_unit.sv
// tb_multu_unit: directed multiplies with a scoreboard queue checked by a done-driven monitor
module tb_multu_unit;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last = '0;
  always #5 clk = ~clk;
  multu_if #(.WIDTH(32)) bus ();
  multu_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .m(bus));
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.done) begin
      done_cnt++;
      if (exp_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else chk("product", {bus.hi, bus.lo}, exp_q.pop_front());
    end
  end
  task automatic run_mul(input logic [31:0] x, input logic [31:0] y, input logic [63:0] e,
                         input bit hold, input bit scramble);
    int sc = 0, bc = 0, hv = 0, dk = -1;
    bus.a = x;
    bus.b = y;
    bus.start = 1'b1;
    exp_q.push_back(e);
    for (int k = 0; k <= 60; k++) begin
      if (k > 0) begin
        @(negedge clk);
        bus.start = hold && k <= 33;
        if (scramble) begin
          bus.a = $urandom;
          bus.b = $urandom;
        end
      end
      #1;
      if (bus.stall) sc++;
      if (bus.busy) bc++;
      if (bus.done) begin
        dk = k;
        break;
      end
      if ({bus.hi, bus.lo} !== last) hv++;
    end
    chk("done_latency", 64'(dk), 64'd33);
    chk("stall_cycles", 64'(sc), 64'd33);
    chk("busy_cycles", 64'(bc), 64'd32);
    chk("hilo_hold", 64'(hv), 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk("done_low_after", 64'(bus.done), 64'd0);
    chk("stall_low_after", 64'(bus.stall), 64'd0);
    last = e;
  endtask
  initial begin
    int dev = 0, snap;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    repeat (50) begin
      @(negedge clk);
      #1;
      if ({bus.hi, bus.lo, bus.busy, bus.done, bus.stall} !== '0) dev++;
    end
    chk("idle_quiet", 64'(dev), 64'd0);
    @(negedge clk);
    run_mul(32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0, 1'b0);
    @(negedge clk);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b0);
    @(negedge clk);
    run_mul(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 1'b1, 1'b0);
    snap = done_cnt;
    repeat (40) @(negedge clk);
    chk("no_reissue", 64'(done_cnt - snap), 64'd0);
    run_mul(32'd0, 32'h1234_5678, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    snap = done_cnt;
    run_mul(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b0, 1'b1);
    @(negedge clk);
    run_mul(32'd7, 32'd6, 64'd42, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b_done_pulses", 64'(done_cnt - snap), 64'd2);
    bus.a = 32'hFFFF;
    bus.b = 32'hFFFF;
    bus.start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    snap = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_hi", 64'(bus.hi), 64'd0);
    chk("abort_lo", 64'(bus.lo), 64'd0);
    chk("abort_stall", 64'(bus.stall), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    repeat (40) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - snap), 64'd0);
    last = '0;
    run_mul(32'd2, 32'd3, 64'd6, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("total_done_pulses", 64'(done_cnt), 64'd7);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
